// File: rtl/vec3_length_if.sv
// Handshake bundle for vec3_length: operand side {x,y,z} in, magnitude side out.
interface vec3_length_if #(
   parameter int W = 32
);
   logic [3*W-1:0] in_vec;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   out_len;
   logic           out_sat;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_vec, in_valid, out_ready,
      input  in_ready, out_len, out_sat, out_valid
   );

   modport slave (
      input  in_vec, in_valid, out_ready,
      output in_ready, out_len, out_sat, out_valid
   );
endinterface

// File: rtl/vec3_length.sv
// Iterative |v| = sqrt(x^2+y^2+z^2) for signed fixed-point vec3, one root bit per cycle.
// The integer root of the 2F-fraction sum of squares lands directly in fixed format.
module vec3_length #(
   parameter int W = 32,
   parameter int F = 16
) (
   input  logic         clk_in,
   input  logic         rst_in,
   vec3_length_if.slave bus
);
   localparam int unsigned R  = W + 1;
   localparam int unsigned SW = 2 * W + 2;
   localparam int unsigned RQ = W + 2;
   localparam int unsigned RW = W + 4;
   localparam int unsigned CW = $clog2(R);
   localparam logic [R-1:0] MAX_POS = {2'b00, {(W-1){1'b1}}};

   if (F <= 0 || F >= W) begin : g_bad_format
      $error("vec3_length: F must lie in 1..W-1");
   end

   typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

   state_t         state, state_nxt;
   logic [3*W-1:0] vec_q;
   logic [SW-1:0]  rad_q;
   logic [RQ-1:0]  rem_q;
   logic [R-1:0]   root_q;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   len_q;
   logic           sat_q;

   logic signed [W-1:0]   x, y, z;
   logic signed [2*W-1:0] xx, yy, zz;
   logic [SW-1:0]         sum_sq;
   logic [RW-1:0]         rem_sh, trial;
   logic                  fits, last;
   logic [R-1:0]          root_nxt;

   assign x = vec_q[3*W-1 -: W];
   assign y = vec_q[2*W-1 -: W];
   assign z = vec_q[W-1:0];

   // Full-width signed squares are non-negative, so zero-extension into S is exact.
   assign xx     = x * x;
   assign yy     = y * y;
   assign zz     = z * z;
   assign sum_sq = {2'b00, xx} + {2'b00, yy} + {2'b00, zz};

   assign rem_sh   = {rem_q, rad_q[SW-1 -: 2]};
   assign trial    = {1'b0, root_q, 2'b01};
   assign fits     = (rem_sh >= trial);
   assign root_nxt = {root_q[R-2:0], fits};
   assign last     = (cnt_q == CW'(R - 1));

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.in_valid)  state_nxt = SQUARE;
         SQUARE:  state_nxt = ROOT;
         ROOT:    if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         vec_q  <= '0;
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (bus.in_valid) vec_q <= bus.in_vec;
            SQUARE: begin
               rad_q  <= sum_sq;
               rem_q  <= '0;
               root_q <= '0;
               cnt_q  <= '0;
            end
            ROOT: begin
               // Remainder stays below 2*root < 2^(W+1), so RQ bits hold it.
               rad_q  <= {rad_q[SW-3:0], 2'b00};
               rem_q  <= RQ'(fits ? rem_sh - trial : rem_sh);
               root_q <= root_nxt;
               cnt_q  <= cnt_q + CW'(1);
               if (last) begin
                  sat_q <= (root_nxt > MAX_POS);
                  len_q <= (root_nxt > MAX_POS) ? MAX_POS[W-1:0] : root_nxt[W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_len   = len_q;
   assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_vec3_length.sv
// Randomized and directed bench for vec3_length against an arithmetic magnitude model.
module tb_vec3_length;
   localparam int W       = 32;
   localparam int LAT     = 35;
   localparam int SPACING = 36;

   logic clk_in = 1'b0;
   logic rst_in;

   vec3_length_if #(.W(W)) bus ();
   vec3_length #(.W(W), .F(16)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

   always #5 clk_in = ~clk_in;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [32:0] exp_q[$];
   int          acc_q[$];
   int          acc_cnt = 0;
   int          last_acc = -1;
   int          rise_cnt = 0;
   bit          chk_spacing = 1'b0;
   logic        prev_ov = 1'b0;
   logic [31:0] last_len = '0;
   logic        last_sat = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Magnitude from plain arithmetic: largest r with r*r <= x^2+y^2+z^2, then clamp.
   function automatic logic [32:0] ref_len(input logic [95:0] v);
      logic [65:0] s = '0;
      logic [32:0] r = '0;
      logic [32:0] cand;
      for (int k = 0; k < 3; k++) begin
         longint c = longint'($signed(v[k*32 +: 32]));
         s += 66'(c * c);
      end
      for (int b = 32; b >= 0; b--) begin
         cand = r | (33'd1 << b);
         if (66'(cand) * 66'(cand) <= s) r = cand;
      end
      if (r > 33'h0_7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
      return {1'b0, r[31:0]};
   endfunction

   function automatic logic [31:0] rand_comp();
      logic [31:0] ext[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF};
      unique case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($signed($urandom_range(0, 262144)) - 131072);
         2:       return ext[$urandom_range(0, 4)];
         default: return {{8{1'b0}}, 24'($urandom)} - 32'h0080_0000;
      endcase
   endfunction

   // Samples pre-edge values at the negedge, then advances one clock.
   task automatic tick();
      logic [32:0] e;
      if (rst_in) begin
         exp_q.delete();
         acc_q.delete();
         prev_ov  = 1'b0;
         last_acc = -1;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_len(bus.in_vec));
            acc_q.push_back(cyc + 1);
            if (chk_spacing && last_acc >= 0) chk("spacing", 64'(cyc + 1 - last_acc), 64'(SPACING));
            last_acc = cyc + 1;
            acc_cnt++;
         end
         if (bus.out_valid && !prev_ov) begin
            rise_cnt++;
            if (acc_q.size() == 0) chk("orphan_valid", 64'(bus.out_valid), 64'(0));
            else                   chk("latency", 64'(cyc + 1 - acc_q.pop_front()), 64'(LAT));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("orphan_result", 64'(bus.out_valid), 64'(0));
            else begin
               e = exp_q.pop_front();
               chk("len", 64'(bus.out_len), 64'(e[31:0]));
               chk("sat", 64'(bus.out_sat), 64'(e[32]));
               last_len = bus.out_len;
               last_sat = bus.out_sat;
            end
         end
         prev_ov = bus.out_valid;
      end
      @(posedge clk_in);
      cyc++;
      @(negedge clk_in);
   endtask

   task automatic send(input logic [95:0] v);
      int a0 = acc_cnt;
      bus.in_vec   = v;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && acc_cnt == a0; i++) tick();
      bus.in_valid = 1'b0;
      chk("accept_timeout", 64'(acc_cnt - a0), 64'(1));
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
      chk("drain_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic run_one(input logic [95:0] v, input logic [31:0] xl, input logic xs);
      send(v);
      drain();
      chk("dir_len", 64'(last_len), 64'(xl));
      chk("dir_sat", 64'(last_sat), 64'(xs));
   endtask

   initial begin
      int a0, r0;
      rst_in        = 1'b1;
      bus.in_vec    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      rst_in = 1'b0;
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_len",   64'(bus.out_len),   64'(0));
      chk("rst_sat",   64'(bus.out_sat),   64'(0));
      chk("rst_ready", 64'(bus.in_ready),  64'(1));

      run_one({32'h0003_0000, 32'h0004_0000, 32'h0}, 32'h0005_0000, 1'b0);
      run_one({32'hFFFD_0000, 32'h0, 32'hFFFC_0000}, 32'h0005_0000, 1'b0);
      run_one({32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, 32'h0001_BB67, 1'b0);
      run_one({32'h0, 32'h0, 32'h0}, 32'h0, 1'b0);
      run_one({32'h1, 32'h0, 32'h0}, 32'h1, 1'b0);
      run_one({32'h1, 32'h1, 32'h0}, 32'h1, 1'b0);
      run_one({32'h8000_0000, 32'h8000_0000, 32'h8000_0000}, 32'h7FFF_FFFF, 1'b1);
      run_one({32'h7FFF_FFFF, 32'h0, 32'h0}, 32'h7FFF_FFFF, 1'b0);

      // Backpressure: result must hold, producer pulse must be ignored.
      bus.out_ready = 1'b0;
      send({32'h0002_0000, 32'hFFFE_0000, 32'h0001_0000});
      for (int i = 0; i < 100 && !bus.out_valid; i++) tick();
      chk("stall_valid", 64'(bus.out_valid), 64'(1));
      a0 = acc_cnt;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = (i == 5);
         bus.in_vec   = {32'h0009_0000, 32'h0, 32'h0};
         chk("stall_len",   64'(bus.out_len),  64'(32'h0003_0000));
         chk("stall_ready", 64'(bus.in_ready), 64'(0));
         tick();
      end
      bus.in_valid = 1'b0;
      chk("stall_ignored", 64'(acc_cnt), 64'(a0));
      bus.out_ready = 1'b1;
      tick();
      chk("ready_after_hs", 64'(bus.in_ready), 64'(1));
      chk("drop_valid",     64'(bus.out_valid), 64'(0));
      drain();

      // Back-to-back random stream with producer always valid.
      chk_spacing  = 1'b1;
      last_acc     = -1;
      bus.in_valid = 1'b1;
      for (int n = 0; n < 16; n++) begin
         a0 = acc_cnt;
         bus.in_vec = {rand_comp(), rand_comp(), rand_comp()};
         for (int i = 0; i < 100 && acc_cnt == a0; i++) tick();
         chk("stream_accept", 64'(acc_cnt - a0), 64'(1));
      end
      bus.in_valid = 1'b0;
      chk_spacing  = 1'b0;
      drain();

      // Reset during ROOT discards the operand.
      send({32'h0005_0000, 32'h0005_0000, 32'h0005_0000});
      repeat (9) tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk("midrst_ready", 64'(bus.in_ready),  64'(1));
      chk("midrst_valid", 64'(bus.out_valid), 64'(0));
      r0 = rise_cnt;
      repeat (40) tick();
      chk("midrst_no_result", 64'(rise_cnt), 64'(r0));
      run_one({32'h0, 32'h0006_0000, 32'h0008_0000}, 32'h000A_0000, 1'b0);

      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
